// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl
//   N-way set-associative cache controller between a CPU load/store port and
//   main memory. One word per line, write-through with write-allocate, true-LRU
//   replacement, one request outstanding. Memory latency is arbitrary.
//
//   Optional feature macro: CACHE_STATS_EN builds saturating hit/miss counters.
//   When the macro is undefined, hit_count/miss_count are tied to 0.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/      CPU request (transfer on cpu_req & cpu_ready)
//   cpu_wdata/cpu_ready
//   cpu_rvalid/cpu_rdata          read response pulse and held read data
//   cpu_wack                      write-complete pulse
//   cpu_hit                       hit/miss qualifier for rvalid/wack
//   mem_req/mem_we/mem_addr/      memory request, held until mem_ack
//   mem_wdata
//   mem_ack/mem_rdata             memory completion and read data
//   hit_count/miss_count          request statistics
module set_assoc_cache_ctrl #(
    parameter int WAYS   = 4,
    parameter int SETS   = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              cpu_wack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-3:0] req_wa_p0;
    logic              req_we_p0;
    logic [DATA_W-1:0] req_wdata_p0;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    logic              valid_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way, vic_way, fill_way, touch_way, touch_age;
    logic              vic_found, fill_en, touch_en;
    logic [DATA_W-1:0] fill_data;

    // Byte-lane bits of the CPU address carry no information for word lines.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign idx = req_wa_p0[IDX_W-1:0];
    assign tag = req_wa_p0[ADDR_W-3:IDX_W];

    // Tag compare and victim choice for the registered request's set.
    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        vic_way   = '0;
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!vic_found && !valid_q[idx][w]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_MAX) vic_way = WAY_W'(w);
            end
        end
    end
    assign hit = |hit_vec;

    // A write lands in the hit way or allocates the victim; a read fill always
    // uses the victim, which is recomputed here since the set cannot change
    // while the miss is outstanding.
    always_comb begin
        fill_en   = 1'b0;
        fill_way  = vic_way;
        fill_data = req_wdata_p0;
        if (state == S_LOOKUP && req_we_p0) begin
            fill_en = 1'b1;
            if (hit) fill_way = hit_way;
        end else if (state == S_MEM_RD && mem_ack) begin
            fill_en   = 1'b1;
            fill_data = mem_rdata;
        end
        touch_en  = fill_en || (state == S_LOOKUP && !req_we_p0 && hit);
        touch_way = fill_en ? fill_way : hit_way;
        touch_age = age_q[idx][touch_way];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
            S_LOOKUP: state_nxt = req_we_p0 ? S_MEM_WR : (hit ? S_RESP : S_MEM_RD);
            S_MEM_RD: if (mem_ack) state_nxt = S_RESP;
            S_MEM_WR: if (mem_ack) state_nxt = S_IDLE;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign cpu_ready  = (state == S_IDLE);
    assign cpu_rvalid = (state == S_RESP);
    assign mem_req    = (state == S_MEM_RD) || (state == S_MEM_WR);
    assign mem_we     = (state == S_MEM_WR);
    assign mem_addr   = mem_req ? {req_wa_p0, 2'b00} : '0;
    assign mem_wdata  = mem_we ? req_wdata_p0 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
            cpu_wack  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state    <= state_nxt;
            cpu_wack <= (state == S_MEM_WR) && mem_ack;
            if (fill_en) valid_q[idx][fill_way] <= 1'b1;
            // LRU touch: younger ways age by one, touched way becomes youngest.
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < touch_age)
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
            if (state == S_LOOKUP) begin
                cpu_hit <= hit;
                if (!req_we_p0 && hit) cpu_rdata <= data_q[idx][hit_way];
            end
            if (state == S_MEM_RD && mem_ack) cpu_rdata <= mem_rdata;
        end
    end

    // Request capture on accept (stage p0) and line storage writes.
    always_ff @(posedge clk) begin
        if (cpu_req && cpu_ready) begin
            req_wa_p0    <= cpu_addr[ADDR_W-1:2];
            req_we_p0    <= cpu_we;
            req_wdata_p0 <= cpu_wdata;
        end
        if (fill_en) begin
            tag_q[idx][fill_way]  <= tag;
            data_q[idx][fill_way] <= fill_data;
        end
    end

`ifdef CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else     miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    property p_single_hit;
        @(posedge clk) disable iff (rst) (state == S_LOOKUP) |-> $onehot0(hit_vec);
    endproperty
    a_single_hit: assert property (p_single_hit);

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl (WAYS=4, SETS=256) with a
// variable-latency memory model.
module tb_set_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, cpu_ready, cpu_rvalid, cpu_hit, cpu_wack;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.WAYS(4), .SETS(256), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_hit(cpu_hit), .cpu_wack(cpu_wack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after 'lat' extra request cycles (0 = ack in first req cycle).
    logic [31:0] mem [logic [31:0]];
    int          lat = 3;
    int          wcnt = 0;
    int          req_cyc = 0;
    logic [31:0] last_wa = '0, last_wd = '0, last_ra = '0;

    always @(posedge clk) begin
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            req_cyc++;
            if (wcnt >= lat) begin
                wcnt    = 0;
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    last_wa = mem_addr;
                    last_wd = mem_wdata;
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
                    last_ra = mem_addr;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its response.
    // cyc counts clock edges after the accept edge until the response is seen.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rdat, output logic rhit,
                              output int cyc, output logic done);
        int w;
        w = 0; rdat = '0; rhit = 1'b0; cyc = 0; done = 1'b0;
        while (!cpu_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (we ? cpu_wack : cpu_rvalid) begin
                done = 1'b1; rdat = cpu_rdata; rhit = cpu_hit;
            end
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                      input logic exp_hit);
        logic [31:0] d; logic h; int c; logic ok; int rq0;
        rq0 = req_cyc;
        cpu_access(1'b0, addr, 32'd0, d, h, c, ok);
        chk({tag, "_done"}, ok, 1);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_hit"}, h, exp_hit);
        chk({tag, "_lat"}, c, exp_hit ? 1 : lat + 2);
        if (exp_hit) chk({tag, "_nomem"}, req_cyc - rq0, 0);
        else         chk({tag, "_maddr"}, last_ra, addr & 32'hFFFF_FFFC);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_hit);
        logic [31:0] d; logic h; int c; logic ok;
        cpu_access(1'b1, addr, data, d, h, c, ok);
        chk({tag, "_done"}, ok, 1);
        chk({tag, "_hit"}, h, exp_hit);
        chk({tag, "_lat"}, c, lat + 2);
        chk({tag, "_maddr"}, last_wa, addr & 32'hFFFF_FFFC);
        chk({tag, "_mdata"}, last_wd, data);
    endtask

    task automatic fill_set16();
        wr("f0", 32'h040, 32'd111, 1'b0);
        wr("f1", 32'h440, 32'd222, 1'b0);
        wr("f2", 32'hC40, 32'd333, 1'b0);
        wr("f3", 32'h1C40, 32'd444, 1'b0);
    endtask

    initial begin
        int seen, bad;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        mem[32'h40] = 32'd111;

        // Reset state
        do_reset();
        chk("rst_ready", cpu_ready, 1);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_wack", cpu_wack, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_hitc", hit_count, 0);
        chk("rst_missc", miss_count, 0);

        // 1: read miss then read hit
        rd("s1_miss", 32'h40, 32'd111, 1'b0);
        rd("s1_hit", 32'h40, 32'd111, 1'b1);
        // 6: statistics after one miss and one hit
`ifdef CACHE_STATS_EN
        chk("s6_hitc", hit_count, 1);
        chk("s6_missc", miss_count, 1);
`else
        chk("s6_hitc", hit_count, 0);
        chk("s6_missc", miss_count, 0);
`endif

        // 2: fill set 16, fifth write evicts way0 (0x040)
        do_reset();
        fill_set16();
        wr("s2_evict", 32'h840, 32'd5000, 1'b0);
        rd("s2_rd040", 32'h040, 32'd111, 1'b0);
        // that fill displaced the now-oldest line 0x440; 0xC40 survives
        rd("s2_rdC40", 32'hC40, 32'd333, 1'b1);

        // 3: touching 0x040 makes 0x440 the LRU victim
        do_reset();
        fill_set16();
        rd("s3_hit040", 32'h040, 32'd111, 1'b1);
        wr("s3_wr840", 32'h840, 32'd5000, 1'b0);
        rd("s3_rd440", 32'h440, 32'd222, 1'b0);
        rd("s3_rd040", 32'h040, 32'd111, 1'b1);

        // 4: write hit, then read via an unaligned address of the same word
        wr("s4_wrhit", 32'h440, 32'd999, 1'b1);
        rd("s4_rd443", 32'h443, 32'd999, 1'b1);

        // 5: reset while a read miss waits on memory
        lat = 10;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC40;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (mem_req) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("s5_memreq_seen", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s5_memreq_drop", mem_req, 0);
        chk("s5_ready", cpu_ready, 1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (cpu_rvalid || cpu_wack) bad++;
        end
        chk("s5_no_resp", bad, 0);
        rd("s5_rdC40", 32'hC40, 32'd333, 1'b0);

        // Zero-stall memory
        lat = 0;
        do_reset();
        rd("l0_miss", 32'h40, 32'd111, 1'b0);
        wr("l0_wrhit", 32'h40, 32'd777, 1'b1);
        rd("l0_hit", 32'h40, 32'd777, 1'b1);

        // Ten-cycle memory
        lat = 10;
        do_reset();
        rd("l10_miss", 32'h40, 32'd777, 1'b0);
        wr("l10_wrmiss", 32'h2040, 32'd55, 1'b0);
        rd("l10_hit", 32'h2040, 32'd55, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
